// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter.
// Holds the FSM state encoding and the address-width helper.
package bram_arb_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_e;

   function automatic int calc_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request above the pointer.
// The pointer moves to the granted requester when advance is high.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_idx_hi;
   logic [PTR_W-1:0] w_idx_lo;
   logic [PTR_W-1:0] w_idx;
   logic             w_hit_hi;
   logic             w_hit_lo;

   // Descending scan: the last hit written is the lowest index, both above
   // the pointer (wins) and overall (wrap-around fallback).
   always_comb begin
      w_hit_hi = 1'b0;
      w_hit_lo = 1'b0;
      w_idx_hi = '0;
      w_idx_lo = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_hit_lo = 1'b1;
            w_idx_lo = PTR_W'(i);
            if (PTR_W'(i) > r_ptr) begin
               w_hit_hi = 1'b1;
               w_idx_hi = PTR_W'(i);
            end
         end
      end
      w_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
      gnt   = '0;
      if (w_hit_lo) begin
         gnt[w_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= PTR_W'(N - 1);
      end else if (advance && w_hit_lo) begin
         r_ptr <= w_idx;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one single-port no-change BRAM between NUM_REQ clients,
// with an optional zero-fill sweep after reset.
//
//   state    | meaning
//   ST_CLEAR | sweeping zeros into every entry, requests held off
//   ST_RUN   | arbitrating requests, one RAM access per cycle
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int RAM_WIDTH      = 18,
   parameter int RAM_DEPTH      = 1024,
   parameter int ADDR_W         = calc_addr_w(RAM_DEPTH),
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                           clka,
   input  logic                           rsta_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
   input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             resp_valid,
   output logic [RAM_WIDTH-1:0]           resp_rdata,
   output logic                           busy_clear,
   output logic                           ram_ena,
   output logic                           ram_wea,
   output logic [ADDR_W-1:0]              ram_addra,
   output logic [RAM_WIDTH-1:0]           ram_dina,
   input  logic [RAM_WIDTH-1:0]           ram_douta
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [NUM_REQ-1:0]  r_resp_valid;
   logic [NUM_REQ-1:0]  w_arb_req;
   logic [NUM_REQ-1:0]  w_gnt;
   logic                w_issue;

   // Requests are invisible to the arbiter during reset and the sweep, so a
   // pending request is neither granted nor dropped there.
   assign w_arb_req = (rsta_n && (r_state == ST_RUN)) ? req_valid : '0;
   assign w_issue   = |w_gnt;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .clk     (clka),
      .rst_n   (rsta_n),
      .req     (w_arb_req),
      .advance (w_issue),
      .gnt     (w_gnt)
   );

   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         if (CLEAR_ON_RESET != 0) begin
            r_state <= ST_CLEAR;
         end else begin
            r_state <= ST_RUN;
         end
         r_clr_cnt    <= '0;
         r_resp_valid <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end
         r_resp_valid <= w_gnt & ~req_we;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      ram_ena     = 1'b0;
      ram_wea     = 1'b0;
      ram_addra   = '0;
      ram_dina    = '0;
      if (rsta_n) begin
         case (r_state)
            ST_CLEAR: begin
               ram_ena   = 1'b1;
               ram_wea   = 1'b1;
               ram_addra = r_clr_cnt;
               if (r_clr_cnt == LAST_ADDR) begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               req_ready = w_gnt;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (w_gnt[i]) begin
                     ram_ena   = 1'b1;
                     ram_wea   = req_we[i];
                     ram_addra = req_addr[i*ADDR_W +: ADDR_W];
                     ram_dina  = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_valid = r_resp_valid & {NUM_REQ{rsta_n}};
   assign resp_rdata = ram_douta;
   assign busy_clear = rsta_n ? (r_state == ST_CLEAR) : (CLEAR_ON_RESET != 0);

endmodule
